// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types for the memory-access pipeline stage: bus
//               sizes, control word, execute/memory stage payloads and the
//               stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int XLEN  = 64;
    localparam int BYTES = XLEN / 8;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [BYTES-1:0] strobe_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    // memext=1 selects zero extension of loads, 0 selects sign extension
    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memext;
        msize_t msize;
    } control_t;

    typedef struct packed {
        word_t       aluout;
        control_t    ctl;
        logic [4:0]  dst;
        word_t       pc;
        logic [31:0] raw_instr;
        word_t       memwd;
    } execute_data_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        word_t       result;
        logic        misalign;
    } memory_data_t;

    // Instruction context parked while a bus transaction is outstanding
    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
    } pending_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ABORT = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input control_t c);
        return c.memread | c.memwrite;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_memalign.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_memalign
// Description : Combinational byte-lane helper: store strobe and data
//               alignment, misalignment detection, and load extraction with
//               sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_memalign
    import mem_access_pkg::*;
(
    input  logic [2:0] addr_i,
    input  msize_t     size_i,
    input  logic       memext_i,
    input  word_t      wdata_i,
    input  word_t      rdata_i,
    output strobe_t    strobe_o,
    output word_t      wdata_aligned_o,
    output word_t      rdata_ext_o,
    output logic       misalign_o
);

    logic [5:0] w_shamt;
    word_t      w_rshift;
    logic       w_sext;

    assign w_shamt         = {addr_i, 3'b000};
    assign wdata_aligned_o = wdata_i << w_shamt;

    // Byte enables and natural-alignment check for the requested size
    always_comb begin
        strobe_o   = 8'hFF;
        misalign_o = 1'b0;
        case (size_i)
            MSIZE1: begin
                strobe_o   = 8'h01 << addr_i;
                misalign_o = 1'b0;
            end
            MSIZE2: begin
                strobe_o   = 8'h03 << addr_i;
                misalign_o = addr_i[0];
            end
            MSIZE4: begin
                strobe_o   = 8'h0F << addr_i;
                misalign_o = |addr_i[1:0];
            end
            default: begin
                strobe_o   = 8'hFF;
                misalign_o = |addr_i;
            end
        endcase
    end

    // Shift the addressed bytes down to bit 0, then extend to full width
    always_comb begin
        w_rshift = rdata_i >> w_shamt;
        w_sext   = ~memext_i;
        case (size_i)
            MSIZE1:  rdata_ext_o = {{56{w_sext & w_rshift[7]}},  w_rshift[7:0]};
            MSIZE2:  rdata_ext_o = {{48{w_sext & w_rshift[15]}}, w_rshift[15:0]};
            MSIZE4:  rdata_ext_o = {{32{w_sext & w_rshift[31]}}, w_rshift[31:0]};
            default: rdata_ext_o = w_rshift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory pipeline stage. Passes ALU results through in one
//               cycle, issues aligned loads/stores on the data bus, and
//               survives a flush while a bus transaction is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  execute_data_t dataE,
    output logic          out_valid,
    input  logic          out_ready,
    output memory_data_t  dataM,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output msize_t        dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data
);

    mem_state_t   state_q;
    logic         out_valid_q;
    memory_data_t dataM_q;
    logic         dreq_valid_q;
    word_t        dreq_addr_q;
    msize_t       dreq_size_q;
    strobe_t      dreq_strobe_q;
    word_t        dreq_data_q;
    pending_t     pend_q;

    logic         w_idle;
    logic [2:0]   w_off;
    msize_t       w_size;
    logic         w_memext;
    strobe_t      w_strobe;
    word_t        w_wdata;
    word_t        w_rdata;
    logic         w_misalign;
    logic         w_is_mem;

    // While idle the helper looks at the incoming instruction; once a
    // request is outstanding it looks at the latched request for extraction.
    assign w_idle   = (state_q == IDLE);
    assign w_off    = w_idle ? dataE.aluout[2:0]  : dreq_addr_q[2:0];
    assign w_size   = w_idle ? dataE.ctl.msize    : dreq_size_q;
    assign w_memext = w_idle ? dataE.ctl.memext   : pend_q.ctl.memext;
    assign w_is_mem = is_mem_op(dataE.ctl);

    mem_access_memalign u_memalign (
        .addr_i          (w_off),
        .size_i          (w_size),
        .memext_i        (w_memext),
        .wdata_i         (dataE.memwd),
        .rdata_i         (dresp_data),
        .strobe_o        (w_strobe),
        .wdata_aligned_o (w_wdata),
        .rdata_ext_o     (w_rdata),
        .misalign_o      (w_misalign)
    );

    assign in_ready    = w_idle & (~out_valid_q | out_ready);
    assign out_valid   = out_valid_q;
    assign dataM       = dataM_q;
    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = dreq_size_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_data   = dreq_data_q;

    // Stage FSM: accept, issue/hold bus request, complete or discard result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            dataM_q       <= '0;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= MSIZE1;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            pend_q        <= '0;
        end else begin
            // A consumed result drops unless replaced below in this cycle
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (flush) begin
                        out_valid_q <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        if (w_is_mem && !w_misalign) begin
                            state_q          <= REQ;
                            dreq_valid_q     <= 1'b1;
                            dreq_addr_q      <= dataE.aluout;
                            dreq_size_q      <= dataE.ctl.msize;
                            dreq_strobe_q    <= dataE.ctl.memwrite ? w_strobe : '0;
                            dreq_data_q      <= w_wdata;
                            pend_q.pc        <= dataE.pc;
                            pend_q.raw_instr <= dataE.raw_instr;
                            pend_q.dst       <= dataE.dst;
                            pend_q.ctl       <= dataE.ctl;
                        end else begin
                            // ALU ops and misaligned accesses complete at once
                            out_valid_q        <= 1'b1;
                            dataM_q.pc         <= dataE.pc;
                            dataM_q.raw_instr  <= dataE.raw_instr;
                            dataM_q.dst        <= dataE.dst;
                            dataM_q.ctl        <= dataE.ctl;
                            dataM_q.result     <= w_is_mem ? '0 : dataE.aluout;
                            dataM_q.misalign   <= w_is_mem;
                        end
                    end
                end

                REQ: begin
                    if (dresp_data_ok) begin
                        state_q       <= IDLE;
                        dreq_valid_q  <= 1'b0;
                        dreq_strobe_q <= '0;
                        // A flush landing on the completion cycle discards it
                        if (!flush) begin
                            out_valid_q        <= 1'b1;
                            dataM_q.pc         <= pend_q.pc;
                            dataM_q.raw_instr  <= pend_q.raw_instr;
                            dataM_q.dst        <= pend_q.dst;
                            dataM_q.ctl        <= pend_q.ctl;
                            dataM_q.result     <= pend_q.ctl.memwrite ? '0 : w_rdata;
                            dataM_q.misalign   <= 1'b0;
                        end
                    end else if (flush) begin
                        state_q <= ABORT;
                    end
                end

                ABORT: begin
                    // Bus must still finish the transaction; result dropped
                    if (dresp_data_ok) begin
                        state_q       <= IDLE;
                        dreq_valid_q  <= 1'b0;
                        dreq_strobe_q <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          dresp_data_ok = 1'b0;
    execute_data_t dataE = '0;
    word_t         dresp_data = '0;

    logic          in_ready;
    logic          out_valid;
    logic          dreq_valid;
    memory_data_t  dataM;
    word_t         dreq_addr;
    word_t         dreq_data;
    msize_t        dreq_size;
    strobe_t       dreq_strobe;

    always #5 clk = ~clk;

    mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dataE         (dataE),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dataM         (dataM),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit            m_en = 1'b0;
    bit            m_pend = 1'b0;    // a bus transaction is outstanding
    bit            m_abort = 1'b0;   // outstanding transaction was squashed
    bit            m_ov = 1'b0;      // a result is presented to writeback
    memory_data_t  m_dm = '0;
    execute_data_t m_req = '0;

    function automatic int nbytes(input msize_t s);
        return 1 << int'(s);
    endfunction

    function automatic bit is_mis(input word_t a, input msize_t s);
        return (int'(a[2:0]) % nbytes(s)) != 0;
    endfunction

    function automatic strobe_t exp_strobe(input execute_data_t e);
        int m;
        if (!e.ctl.memwrite) return '0;
        m = ((1 << nbytes(e.ctl.msize)) - 1) << int'(e.aluout[2:0]);
        return m[7:0];
    endfunction

    function automatic word_t exp_wdata(input execute_data_t e);
        return e.memwd << (8 * int'(e.aluout[2:0]));
    endfunction

    function automatic word_t exp_load(input word_t rd, input execute_data_t e);
        int    n;
        word_t v;
        word_t mask;
        n = nbytes(e.ctl.msize);
        v = rd >> (8 * int'(e.aluout[2:0]));
        if (n < 8) begin
            mask = (word_t'(1) << (8 * n)) - 1;
            v = v & mask;
            if (!e.ctl.memext && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic memory_data_t mkout(input execute_data_t e, input word_t res, input bit mis);
        memory_data_t d;
        d.pc        = e.pc;
        d.raw_instr = e.raw_instr;
        d.dst       = e.dst;
        d.ctl       = e.ctl;
        d.result    = res;
        d.misalign  = mis;
        return d;
    endfunction

    function automatic execute_data_t mk(input word_t alu, input bit rd, input bit wr,
                                         input bit ext, input msize_t sz, input word_t wd);
        execute_data_t e;
        e = '0;
        e.aluout       = alu;
        e.ctl.regwrite = !wr;
        e.ctl.memread  = rd;
        e.ctl.memwrite = wr;
        e.ctl.memext   = ext;
        e.ctl.msize    = sz;
        e.dst          = 5'd7;
        e.pc           = 64'h8000_0000 + alu;
        e.raw_instr    = 32'h0000_0013;
        e.memwd        = wd;
        return e;
    endfunction

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        if (m_en && reset) begin
            chk("in_ready", {255'd0, in_ready}, {255'd0, (!m_pend && (!m_ov || out_ready))});
            chk("out_valid", {255'd0, out_valid}, {255'd0, m_ov});
            if (m_ov) chk("dataM", dataM, m_dm);
            chk("dreq_valid", {255'd0, dreq_valid}, {255'd0, m_pend});
            if (m_pend) begin
                chk("dreq_addr", dreq_addr, m_req.aluout);
                chk("dreq_size", dreq_size, m_req.ctl.msize);
                chk("dreq_strobe", dreq_strobe, exp_strobe(m_req));
                chk("dreq_data", dreq_data, exp_wdata(m_req));
            end
        end
    end

    // Drive one cycle of inputs, advance the model across the clock edge
    task automatic cycle(input logic iv, input execute_data_t e, input logic ordy,
                         input logic fl, input logic dok, input word_t rd);
        bit            n_pend;
        bit            n_abort;
        bit            n_ov;
        bit            rdy;
        bit            memop;
        memory_data_t  n_dm;
        execute_data_t n_req;
        n_pend  = m_pend;
        n_abort = m_abort;
        n_ov    = m_ov;
        n_dm    = m_dm;
        n_req   = m_req;
        in_valid      = iv;
        dataE         = e;
        out_ready     = ordy;
        flush         = fl;
        dresp_data_ok = dok;
        dresp_data    = rd;
        rdy   = !m_pend && (!m_ov || ordy);
        memop = e.ctl.memread || e.ctl.memwrite;
        if (m_ov && ordy) n_ov = 0;
        if (m_pend) begin
            if (dok) begin
                n_pend  = 0;
                n_abort = 0;
                if (!m_abort && !fl) begin
                    n_ov = 1;
                    n_dm = mkout(m_req, m_req.ctl.memwrite ? 64'd0 : exp_load(rd, m_req), 0);
                end
            end else if (fl) begin
                n_abort = 1;
            end
        end else if (fl) begin
            n_ov = 0;
        end else if (iv && rdy) begin
            if (memop && !is_mis(e.aluout, e.ctl.msize)) begin
                n_pend = 1;
                n_req  = e;
            end else begin
                n_ov = 1;
                n_dm = mkout(e, memop ? 64'd0 : e.aluout, memop);
            end
        end
        @(posedge clk);
        m_pend  = n_pend;
        m_abort = n_abort;
        m_ov    = n_ov;
        m_dm    = n_dm;
        m_req   = n_req;
        #1;
    endtask

    task automatic idle(input logic dok, input word_t rd);
        cycle(1'b0, '0, 1'b1, 1'b0, dok, rd);
    endtask

    task automatic rand_cycle();
        execute_data_t e;
        msize_t        sz;
        word_t         a;
        int            op;
        logic          dok;
        op = $urandom_range(0, 2);
        sz = msize_t'($urandom_range(0, 3));
        a  = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) a = a & ~(word_t'(nbytes(sz) - 1));
        e = mk(a, op == 1, op == 2, $urandom_range(0, 1) == 1, sz, {$urandom, $urandom});
        e.dst       = 5'($urandom);
        e.raw_instr = $urandom;
        dok = m_pend ? ($urandom_range(0, 2) == 0) : 1'b0;
        cycle($urandom_range(0, 3) != 0, e, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, dok, {$urandom, $urandom});
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_abort = 0;
        m_ov    = 0;
        m_dm    = '0;
        m_req   = '0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_dreq_valid", {255'd0, dreq_valid}, 256'd0);
        chk("rst_dreq_strobe", dreq_strobe, 256'd0);
        chk("rst_dataM", dataM, 256'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        reset = 1'b1;
        model_reset();
        m_en = 1'b1;

        // ALU pass-through
        cycle(1'b1, mk(64'h1234, 0, 0, 0, MSIZE8, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        chk("alu_valid", {255'd0, out_valid}, 256'd1);
        chk("alu_result", dataM.result, 256'h1234);
        chk("alu_noreq", {255'd0, dreq_valid}, 256'd0);

        // Byte store at 0x1003, data_ok on the third request cycle
        cycle(1'b1, mk(64'h1003, 0, 1, 0, MSIZE1, 64'hAB), 1'b1, 1'b0, 1'b0, 64'd0);
        chk("st_req", {255'd0, dreq_valid}, 256'd1);
        chk("st_strobe", dreq_strobe, 256'h08);
        chk("st_data", dreq_data, 256'hAB00_0000);
        idle(1'b0, 64'd0);
        idle(1'b0, 64'd0);
        idle(1'b1, 64'hDEAD_BEEF);
        chk("st_done_valid", {255'd0, out_valid}, 256'd1);
        chk("st_result", dataM.result, 256'd0);
        chk("st_req_drop", {255'd0, dreq_valid}, 256'd0);

        // Signed and unsigned halfword loads at 0x2006
        cycle(1'b1, mk(64'h2006, 1, 0, 0, MSIZE2, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        idle(1'b1, 64'h8001_0000_0000_0000);
        chk("lh_result", dataM.result, 256'hFFFF_FFFF_FFFF_8001);
        chk("lh_model", m_dm.result, 256'hFFFF_FFFF_FFFF_8001);
        cycle(1'b1, mk(64'h2006, 1, 0, 1, MSIZE2, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        idle(1'b1, 64'h8001_0000_0000_0000);
        chk("lhu_result", dataM.result, 256'h8001);

        // Misaligned word load
        cycle(1'b1, mk(64'h2002, 1, 0, 0, MSIZE4, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        chk("mis_flag", {255'd0, dataM.misalign}, 256'd1);
        chk("mis_valid", {255'd0, out_valid}, 256'd1);
        chk("mis_noreq", {255'd0, dreq_valid}, 256'd0);
        chk("mis_result", dataM.result, 256'd0);

        // Flush while the request is outstanding
        cycle(1'b1, mk(64'h3000, 1, 0, 0, MSIZE8, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 64'd0);
        chk("fl_in_ready", {255'd0, in_ready}, 256'd0);
        idle(1'b0, 64'd0);
        chk("fl_hold_req", {255'd0, dreq_valid}, 256'd1);
        idle(1'b1, 64'h1111_2222_3333_4444);
        chk("fl_no_out", {255'd0, out_valid}, 256'd0);
        chk("fl_ready", {255'd0, in_ready}, 256'd1);

        // Asynchronous reset in the middle of a request
        cycle(1'b1, mk(64'h4008, 1, 0, 0, MSIZE8, 64'd0), 1'b1, 1'b0, 1'b0, 64'd0);
        in_valid = 1'b0;
        #2;
        m_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_dreq", {255'd0, dreq_valid}, 256'd0);
        chk("arst_out", {255'd0, out_valid}, 256'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("arst_ready", {255'd0, in_ready}, 256'd1);
        m_en = 1'b1;

        // Randomized traffic
        repeat (4000) rand_cycle();
        repeat (10) idle(m_pend, {$urandom, $urandom});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
